// File: rtl/f8_uart_pkg.sv
// Shared constants and state types for the f8 UART.
package f8_uart_pkg;

  // Register addresses
  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrDiv    = 2'd2;

  // STATUS bit positions
  localparam int unsigned StRxAvail = 0;
  localparam int unsigned StTxSpace = 1;
  localparam int unsigned StTxIdle  = 2;
  localparam int unsigned StRxOvr   = 3;
  localparam int unsigned StFrmErr  = 4;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with combinational head. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/f8_uart.sv
// f8 UART: bus register file, 16x tick generator, RX and TX 8N1 engines.
module f8_uart
  import f8_uart_pkg::*;
#(
  parameter int unsigned BAUDDIV   = 13,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       re,
  output logic [7:0] rdata,
  input  logic       rx,
  output logic       tx
);

  // Bus decode
  logic wr_data, wr_status, wr_div, rd_data;
  assign wr_data   = we && (addr == AddrData);
  assign wr_status = we && (addr == AddrStatus);
  assign wr_div    = we && (addr == AddrDiv);
  assign rd_data   = re && (addr == AddrData);

  // Tick generator
  logic [7:0] div_q, cnt_q, cnt_d, div_eff;
  logic       tick;

  assign div_eff = (div_q == 8'd0) ? 8'd1 : div_q;
  assign tick    = (cnt_q <= 8'd1);

  // Divisor reload on write or on tick, otherwise count down
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (wr_div)    cnt_d = (wdata == 8'd0) ? 8'd1 : wdata;
    else if (tick) cnt_d = div_eff;
  end

  // Divisor register and tick counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 8'(BAUDDIV);
      cnt_q <= 8'(BAUDDIV);
    end else begin
      if (wr_div) div_q <= wdata;
      cnt_q <= cnt_d;
    end
  end

  // FIFOs
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic [7:0] rx_shift_q, rx_shift_d;

  assign rx_pop = rd_data && !rx_empty;

  uart_fifo #(.Depth(FIFODEPTH), .Width(8)) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  uart_fifo #(.Depth(FIFODEPTH), .Width(8)) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (wr_data),
    .wdata_i (wdata),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // ---------------- RX ----------------
  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_os_q, rx_os_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_meta_q, rx_sync_q;
  logic       rx_stop_smp, frm_set, ovr_set;

  // RX state register and synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: start at first low tick, validate at count 7, then 16 ticks per bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    if (tick) begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_state_d = RxStart;
            rx_os_d    = '0;
          end
        end
        RxStart: begin
          if (rx_os_q == 4'd7) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_os_d = rx_os_q + 4'd1;
          end
        end
        RxData: begin
          if (rx_os_q == 4'd15) begin
            rx_os_d    = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_os_d = rx_os_q + 4'd1;
          end
        end
        RxStop: begin
          if (rx_os_q == 4'd15) begin
            rx_os_d    = '0;
            rx_state_d = RxIdle;
          end else begin
            rx_os_d = rx_os_q + 4'd1;
          end
        end
      endcase
    end
  end

  // RX outputs: push on good stop bit, flag errors
  always_comb begin
    rx_stop_smp = tick && (rx_state_q == RxStop) && (rx_os_q == 4'd15);
    rx_push     = rx_stop_smp && rx_sync_q;
    frm_set     = rx_stop_smp && !rx_sync_q;
    ovr_set     = rx_push && rx_full && !rx_pop;
  end

  // ---------------- TX ----------------
  tx_state_t  tx_state_q, tx_state_d;
  logic [3:0] tx_os_q, tx_os_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d;

  // A frame may start from idle or directly after a stop bit
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && (tx_os_q == 4'd15)));

  // TX state register; line resets high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: each bit lasts 16 ticks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tick) begin
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            tx_state_d = TxStart;
            tx_os_d    = '0;
            tx_shift_d = tx_head;
          end
        end
        TxStart: begin
          if (tx_os_q == 4'd15) begin
            tx_state_d = TxData;
            tx_os_d    = '0;
            tx_bit_d   = '0;
          end else begin
            tx_os_d = tx_os_q + 4'd1;
          end
        end
        TxData: begin
          if (tx_os_q == 4'd15) begin
            tx_os_d    = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            else                  tx_bit_d   = tx_bit_q + 3'd1;
          end else begin
            tx_os_d = tx_os_q + 4'd1;
          end
        end
        TxStop: begin
          if (tx_os_q == 4'd15) begin
            tx_os_d = '0;
            if (tx_pop) begin
              tx_state_d = TxStart;
              tx_shift_d = tx_head;
            end else begin
              tx_state_d = TxIdle;
            end
          end else begin
            tx_os_d = tx_os_q + 4'd1;
          end
        end
      endcase
    end
  end

  // TX output: line level registered from the next state
  always_comb begin
    case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // ---------------- Status / read mux ----------------
  logic ovr_q, ovr_d, frm_q, frm_d;

  // Sticky flags: write-1-to-clear, a same-cycle set wins
  always_comb begin
    ovr_d = ovr_set | (ovr_q & ~(wr_status & wdata[StRxOvr]));
    frm_d = frm_set | (frm_q & ~(wr_status & wdata[StFrmErr]));
  end

  // Sticky flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      frm_q <= frm_d;
    end
  end

  // Combinational register read
  always_comb begin
    logic [7:0] status;
    status            = 8'h00;
    status[StRxAvail] = !rx_empty;
    status[StTxSpace] = !tx_full;
    status[StTxIdle]  = tx_empty && (tx_state_q == TxIdle);
    status[StRxOvr]   = ovr_q;
    status[StFrmErr]  = frm_q;
    case (addr)
      AddrData:   rdata = rx_empty ? 8'h00 : rx_head;
      AddrStatus: rdata = status;
      AddrDiv:    rdata = div_q;
      default:    rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_f8_uart.sv
// Directed bench for f8_uart: registers, TX waveform, loopback, overrun,
// framing error, glitch rejection and mid-frame reset.
module tb_f8_uart;
  import f8_uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       we, re;
  logic [7:0] rdata;
  logic       tx;
  logic       rx_drv, loop_en;
  logic       rx_line;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  f8_uart #(.BAUDDIV(13), .FIFODEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .rx      (rx_line),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    addr = a; re = 1'b0;
    #1 d = rdata;
  endtask

  // Drives one 8N1 frame at DIV=1 (16 cycles per bit); stop bit held stop_len cycles
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (stop_len) @(negedge clk);
    rx_drv = 1'b1;
    if (stop_len < 16) repeat (16 - stop_len) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [9:0] frame;
    logic [7:0] exp_b [4];
    int t0, lows;
    bit idle_seen;

    reset_n = 1'b0; addr = 2'd0; wdata = 8'h00; we = 1'b0; re = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("tx_in_reset", 32'(tx), 32'd1);
    end
    reset_n = 1'b1;
    bus_read(AddrStatus, d); check_eq("status_reset", 32'(d), 32'h06);
    bus_read(AddrDiv, d);    check_eq("div_reset", 32'(d), 32'd13);
    bus_read(2'd3, d);       check_eq("addr3_zero", 32'(d), 32'h00);
    bus_read(AddrData, d);   check_eq("data_empty", 32'(d), 32'h00);
    bus_write(AddrDiv, 8'h00);
    bus_read(AddrDiv, d);    check_eq("div_zero_rb", 32'(d), 32'h00);
    bus_write(AddrDiv, 8'h01);

    // Single TX frame 0xA5
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(AddrData, 8'hA5);
    check_eq("tx_before_start", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("tx_start_latency", 32'(tx), 32'd0);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("tx_a5_bit%0d", i), 32'(tx), 32'(frame[i]));
      if (i == 4) begin
        peek(AddrStatus, d);
        check_eq("status_tx_busy", 32'(d), 32'h02);
      end
      repeat (16) @(negedge clk);
    end
    peek(AddrStatus, d);
    check_eq("status_tx_done", 32'(d), 32'h06);

    // Loopback, back-to-back frames
    loop_en = 1'b1;
    exp_b = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    bus_write(AddrData, exp_b[0]);
    t0 = cyc;
    for (int i = 1; i < 4; i++) bus_write(AddrData, exp_b[i]);
    idle_seen = 1'b0;
    for (int i = 0; i < 2000 && !idle_seen; i++) begin
      @(negedge clk);
      peek(AddrStatus, d);
      if (d[StTxIdle]) idle_seen = 1'b1;
    end
    check_eq("b2b_frames_cycles", 32'(cyc - t0), 32'd641);
    loop_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(AddrData, d);
      check_eq($sformatf("loop_rx%0d", i), 32'(d), 32'(exp_b[i]));
    end
    bus_read(AddrStatus, d); check_eq("status_after_loop", 32'(d), 32'h06);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b1, 16);
    repeat (4) @(negedge clk);
    bus_read(AddrStatus, d); check_eq("status_overrun", 32'(d), 32'h0F);
    for (int i = 1; i <= 4; i++) begin
      bus_read(AddrData, d);
      check_eq($sformatf("ovr_rx%0d", i), 32'(d), 32'(i * 8'h11));
    end
    bus_read(AddrData, d);   check_eq("ovr_fifth_dropped", 32'(d), 32'h00);
    bus_read(AddrStatus, d); check_eq("status_ovr_sticky", 32'(d), 32'h0E);
    bus_write(AddrStatus, 8'h08);
    bus_read(AddrStatus, d); check_eq("status_ovr_clear", 32'(d), 32'h06);

    // Framing error
    send_frame(8'h55, 1'b0, 12);
    repeat (20) @(negedge clk);
    bus_read(AddrStatus, d); check_eq("status_frm_err", 32'(d), 32'h16);
    bus_write(AddrStatus, 8'h10);
    bus_read(AddrStatus, d); check_eq("status_frm_clear", 32'(d), 32'h06);

    // Three-cycle glitch must be ignored; a following frame still decodes
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(AddrStatus, d); check_eq("status_glitch", 32'(d), 32'h06);
    send_frame(8'h3C, 1'b1, 16);
    repeat (4) @(negedge clk);
    bus_read(AddrData, d);   check_eq("rx_after_glitch", 32'(d), 32'h3C);

    // TX FIFO full, then reset mid-frame
    bus_write(AddrDiv, 8'd200);
    for (int i = 0; i < 4; i++) bus_write(AddrData, 8'h00);
    peek(AddrStatus, d);
    check_eq("status_tx_full", 32'(d), 32'h00);
    bus_write(AddrDiv, 8'h01);
    repeat (40) @(negedge clk);
    check_eq("tx_mid_frame", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1 check_eq("tx_async_reset", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("tx_quiet_after_reset", 32'(lows), 32'd0);
    bus_read(AddrStatus, d); check_eq("status_post_reset", 32'(d), 32'h06);
    bus_read(AddrDiv, d);    check_eq("div_post_reset", 32'(d), 32'd13);
    bus_read(AddrData, d);   check_eq("data_post_reset", 32'(d), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
